// File: rtl/sram_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | sram_arb_pkg : shared types, constants and byte-merge helper for the       |
// |                SRAM port arbiter.                       Revision: 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

package sram_arb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACC   = 3'd1,
      RESP  = 3'd2,
      MERGE = 3'd3,
      WR    = 3'd4
   } state_t;

   localparam logic [3:0] BE_FULL = 4'hF;

   // Byte k comes from the new write data when its strobe is set, else from the old word.
   function automatic logic [31:0] merge_bytes(
      input logic [31:0] wdata,
      input logic [31:0] rdata,
      input logic [3:0]  be
   );
      logic [31:0] m;
      m = rdata;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) begin
            m[8*k +: 8] = wdata[8*k +: 8];
         end
      end
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter : round-robin arbiter with one-hot grant; the pointer moves to  |
// |              winner+1 whenever a grant is taken.        Revision: 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               grant_en_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic               any_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W-1:0] w_win;
   logic             w_found;

   // Two passes: requesters at or above the pointer first, then the wrapped-around ones.
   always_comb begin
      grant_o = '0;
      w_found = 1'b0;
      w_win   = ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && (i >= int'(ptr_q)) && req_i[i]) begin
            w_found    = 1'b1;
            grant_o[i] = 1'b1;
            w_win      = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && (i < int'(ptr_q)) && req_i[i]) begin
            w_found    = 1'b1;
            grant_o[i] = 1'b1;
            w_win      = IDX_W'(i);
         end
      end
   end

   assign any_o = w_found;

   always_comb begin
      ptr_d = ptr_q;
      if (grant_en_i && w_found) begin
         ptr_d = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : (w_win + IDX_W'(1));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | sram_port_arbiter : round-robin sharing of one 512x32 SRAM wrapper, with   |
// |                     byte-strobe writes by read-modify-write. Rev: 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ-1:0]          req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*(DATA_W/8)-1:0] req_be,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          resp_valid,
   output logic [DATA_W-1:0]           resp_rdata,
   output logic                        busy,
   output logic                        sram_en,
   output logic                        sram_wen,
   output logic [ADDR_W-1:0]           sram_addr,
   output logic [DATA_W-1:0]           sram_wdata,
   input  logic [DATA_W-1:0]           sram_rdata
);

   localparam int NB = DATA_W / 8;

   state_t              state_q;
   logic [NUM_REQ-1:0]  owner_q;
   logic                we_q;
   logic [NB-1:0]       be_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [NUM_REQ-1:0]  resp_valid_q;
   logic                sram_en_q;
   logic                sram_wen_q;
   logic [ADDR_W-1:0]   sram_addr_q;
   logic [DATA_W-1:0]   sram_wdata_q;

   logic                w_idle;
   logic [NUM_REQ-1:0]  w_grant;
   logic                w_any;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [NB-1:0]       w_sel_be;
   logic [DATA_W-1:0]   w_sel_wdata;

   assign w_idle = (state_q == IDLE);

   rr_arbiter #(
      .NUM_REQ    (NUM_REQ)
   ) u_rr_arbiter (
      .clk        (clk),
      .reset      (reset),
      .req_i      (req_valid & {NUM_REQ{w_idle}}),
      .grant_en_i (w_idle),
      .grant_o    (w_grant),
      .any_o      (w_any)
   );

   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_be    = '0;
      w_sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_we    = req_we[i];
            w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_be    = req_be[i*NB +: NB];
            w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // The accept pulse is combinational so the requester sees it in the grant cycle.
   assign req_ready  = w_grant & {NUM_REQ{~reset}};
   assign resp_valid = resp_valid_q;
   assign resp_rdata = (state_q == RESP) ? sram_rdata : '0;
   assign busy       = ~w_idle;
   assign sram_en    = sram_en_q;
   assign sram_wen   = sram_wen_q;
   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         we_q         <= 1'b0;
         be_q         <= '0;
         wdata_q      <= '0;
         resp_valid_q <= '0;
         sram_en_q    <= 1'b0;
         sram_wen_q   <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (w_any) begin
                  owner_q <= w_grant;
                  we_q    <= w_sel_we;
                  be_q    <= w_sel_be;
                  wdata_q <= w_sel_wdata;
                  // A write with no strobes completes on accept without touching the SRAM.
                  if (!(w_sel_we && (w_sel_be == '0))) begin
                     state_q     <= ACC;
                     sram_en_q   <= 1'b1;
                     sram_wen_q  <= w_sel_we && (w_sel_be == BE_FULL);
                     sram_addr_q <= w_sel_addr;
                     if (w_sel_we && (w_sel_be == BE_FULL)) begin
                        sram_wdata_q <= w_sel_wdata;
                     end
                  end
               end
            end
            ACC: begin
               sram_en_q  <= 1'b0;
               sram_wen_q <= 1'b0;
               if (!we_q) begin
                  state_q      <= RESP;
                  resp_valid_q <= owner_q;
               end else if (be_q == BE_FULL) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= MERGE;
               end
            end
            RESP: begin
               resp_valid_q <= '0;
               state_q      <= IDLE;
            end
            MERGE: begin
               sram_en_q    <= 1'b1;
               sram_wen_q   <= 1'b1;
               sram_wdata_q <= merge_bytes(wdata_q, sram_rdata, be_q);
               state_q      <= WR;
            end
            WR: begin
               sram_en_q  <= 1'b0;
               sram_wen_q <= 1'b0;
               state_q    <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
